// File: rtl/multi_clock_gen_pkg.sv
// Shared types and constants for the multi-channel clock generator.
package multi_clock_gen_pkg;

    // Width of each per-channel rising-edge counter.
    localparam int COUNT_W = 64;

    // Configuration command opcodes carried on the cfg bus.
    typedef enum logic [1:0] {
        OP_SET_HP   = 2'd0,
        OP_SET_EN   = 2'd1,
        OP_ADVANCE  = 2'd2,
        OP_RESERVED = 2'd3
    } cfg_op_e;

    // Per-channel advance tracker states.
    typedef enum logic [1:0] {
        ADV_IDLE  = 2'd0,
        ADV_COUNT = 2'd1,
        ADV_DONE  = 2'd2
    } adv_state_e;

    // Channel-select width; a single channel still gets a 1-bit field.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_clock_gen_if.sv
// Configuration command bus: valid/ready handshake plus opcode, channel and data.
interface multi_clock_gen_if
    import multi_clock_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    localparam int CH_W = ch_width(NUM_CH);

    logic             valid;
    logic             ready;
    cfg_op_e          op;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] data;

    modport master (output valid, op, ch, data, input ready);
    modport slave  (input valid, op, ch, data, output ready);

endinterface

// File: rtl/multi_clock_gen_ch.sv
// One clock channel: down-counter divider, staged period/enable updates
// applied at rising edges, and an advance tracker that counts rises.
// Rise counter present only when MULTI_CLOCK_GEN_RISE_COUNT_EN is defined.
module multi_clock_gen_ch
    import multi_clock_gen_pkg::*;
#(
    parameter int CNT_W            = 16,
    parameter int INIT_HALF_PERIOD = 2,
    parameter int PHASE_OFFSET     = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               hp_wr,
    input  logic               en_wr,
    input  logic               adv_wr,
    input  logic [CNT_W-1:0]   data,
    output logic               clk_out,
    output logic               clk_rise,
    output logic               adv_done,
    output logic               adv_busy,
    output logic [COUNT_W-1:0] rise_count
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_period;
    logic [CNT_W-1:0] hp_stage;
    logic [CNT_W-1:0] hp_eff;
    logic [CNT_W-1:0] adv_rem;
    logic [CNT_W-1:0] adv_rem_nx;
    logic             clk_int;
    logic             clk_int_nx;
    logic             enable;
    logic             en_stage;
    logic             en_eff;
    logic             hp_pend;
    logic             en_pend;
    logic             hp_wr_ok;
    logic             at_zero;
    logic             rise_now;
    adv_state_e       adv_state;
    adv_state_e       adv_state_nx;

    // rise_now is true in the cycle before clk_rise: the next edge drives the internal clock high.
    assign at_zero    = (cnt == '0);
    assign rise_now   = at_zero && !clk_int;
    assign clk_int_nx = clk_int ^ at_zero;
    assign hp_wr_ok   = hp_wr && (data != '0);

    // Settings used at a rise: a write arriving now beats an older staged value, which beats the current one.
    always_comb begin
        // NOTE: every output gets a default before the ifs so no path leaves it unassigned (no latch).
        hp_eff = half_period;
        en_eff = enable;
        if (rise_now) begin
            if (hp_wr_ok)     hp_eff = data;
            else if (hp_pend) hp_eff = hp_stage;
            if (en_wr)        en_eff = data[0];
            else if (en_pend) en_eff = en_stage;
        end
    end

    // Divider, staging registers and registered clock outputs.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (!reset_n) begin
            cnt         <= CNT_W'(PHASE_OFFSET - 1);
            clk_int     <= 1'b0;
            half_period <= CNT_W'(INIT_HALF_PERIOD);
            enable      <= 1'b1;
            hp_stage    <= '0;
            en_stage    <= 1'b0;
            hp_pend     <= 1'b0;
            en_pend     <= 1'b0;
            clk_out     <= 1'b0;
            clk_rise    <= 1'b0;
        end else begin
            if (at_zero) begin
                clk_int <= !clk_int;
                cnt     <= hp_eff - CNT_W'(1);
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
            half_period <= hp_eff;
            enable      <= en_eff;
            clk_rise    <= rise_now;
            // Built from next-state values so clk_out tracks the internal clock with no lag.
            clk_out     <= clk_int_nx & en_eff;
            if (rise_now) begin
                hp_pend <= 1'b0;
                en_pend <= 1'b0;
            end else begin
                if (hp_wr_ok) begin
                    hp_stage <= data;
                    hp_pend  <= 1'b1;
                end
                if (en_wr) begin
                    en_stage <= data[0];
                    en_pend  <= 1'b1;
                end
            end
        end
    end

    // Advance tracker state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            adv_state <= ADV_IDLE;
            adv_rem   <= '0;
        end else begin
            adv_state <= adv_state_nx;
            adv_rem   <= adv_rem_nx;
        end
    end

    // Advance next state: a new request always restarts; a rise in the accept cycle already counts.
    always_comb begin
        adv_state_nx = adv_state;
        adv_rem_nx   = adv_rem;
        if (adv_wr) begin
            if ((data == '0) || ((data == CNT_W'(1)) && rise_now)) begin
                adv_state_nx = ADV_DONE;
                adv_rem_nx   = '0;
            end else begin
                adv_state_nx = ADV_COUNT;
                adv_rem_nx   = rise_now ? (data - CNT_W'(1)) : data;
            end
        end else begin
            case (adv_state)
                ADV_COUNT: begin
                    if (rise_now) begin
                        adv_rem_nx = adv_rem - CNT_W'(1);
                        if (adv_rem == CNT_W'(1)) adv_state_nx = ADV_DONE;
                    end
                end
                ADV_DONE: adv_state_nx = ADV_IDLE;
                default:  adv_state_nx = adv_state;
            endcase
        end
    end

    assign adv_busy = (adv_state != ADV_IDLE);
    assign adv_done = (adv_state == ADV_DONE);

`ifdef MULTI_CLOCK_GEN_RISE_COUNT_EN
    logic [COUNT_W-1:0] rise_cnt;

    // Rising-edge counter, updated on the same edge as clk_rise so both agree each cycle.
    always_ff @(posedge clock) begin
        if (!reset_n)      rise_cnt <= '0;
        else if (rise_now) rise_cnt <= rise_cnt + COUNT_W'(1);
    end

    assign rise_count = rise_cnt;
`else
    assign rise_count = '0;
`endif

endmodule

// File: rtl/multi_clock_gen.sv
// Multi-channel gated clock generator: decodes cfg commands and fans them out
// to NUM_CH channel instances. Optional macro: MULTI_CLOCK_GEN_RISE_COUNT_EN.
module multi_clock_gen
    import multi_clock_gen_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int CNT_W            = 16,
    parameter int INIT_HALF_PERIOD = 2,
    parameter int PHASE_OFFSET     = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    multi_clock_gen_if.slave          cfg,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         clk_rise,
    output logic [NUM_CH-1:0]         adv_done,
    output logic [NUM_CH-1:0]         adv_busy,
    output logic [NUM_CH*COUNT_W-1:0] rise_count
);

    logic accept;

    // No backpressure: every command is taken while out of reset.
    assign cfg.ready = reset_n;
    assign accept    = cfg.valid && cfg.ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;

        // Out-of-range channel numbers never match, so they are accepted and dropped.
        assign sel = accept && (int'(cfg.ch) == i);

        multi_clock_gen_ch #(
            .CNT_W            (CNT_W),
            .INIT_HALF_PERIOD (INIT_HALF_PERIOD),
            .PHASE_OFFSET     (PHASE_OFFSET)
        ) u_ch (
            .clock      (clock),
            .reset_n    (reset_n),
            .hp_wr      (sel && (cfg.op == OP_SET_HP)),
            .en_wr      (sel && (cfg.op == OP_SET_EN)),
            .adv_wr     (sel && (cfg.op == OP_ADVANCE)),
            .data       (cfg.data),
            .clk_out    (clk_out[i]),
            .clk_rise   (clk_rise[i]),
            .adv_done   (adv_done[i]),
            .adv_busy   (adv_busy[i]),
            .rise_count (rise_count[i*COUNT_W +: COUNT_W])
        );
    end

endmodule

// File: tb/tb_multi_clock_gen.sv
// Self-checking bench for multi_clock_gen: an event-time reference model
// predicts each cycle's outputs when stimulus is driven; the prediction is
// queued and compared against the DUT on the following falling edge.
module tb_multi_clock_gen;
    import multi_clock_gen_pkg::*;

    localparam int NCH   = 3;
    localparam int CNT_W = 16;
    localparam int IHP   = 2;
    localparam int PO    = 1;
    localparam int CH_W  = ch_width(NCH);
    localparam int RCW   = NCH * COUNT_W;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   clk_rise;
    logic [NCH-1:0]   adv_done;
    logic [NCH-1:0]   adv_busy;
    logic [RCW-1:0]   rise_count;

    multi_clock_gen_if #(.NUM_CH(NCH), .CNT_W(CNT_W)) cfg_if ();

    multi_clock_gen #(
        .NUM_CH           (NCH),
        .CNT_W            (CNT_W),
        .INIT_HALF_PERIOD (IHP),
        .PHASE_OFFSET     (PO)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg        (cfg_if),
        .clk_out    (clk_out),
        .clk_rise   (clk_rise),
        .adv_done   (adv_done),
        .adv_busy   (adv_busy),
        .rise_count (rise_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic           ready;
        logic [NCH-1:0] clk_out;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] done;
        logic [NCH-1:0] busy;
        logic [RCW-1:0] rc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc   = 0;

    // Reference model state, kept as absolute cycle numbers of upcoming events.
    int              m_nrise [NCH];
    int              m_hiend [NCH];
    int              m_hp    [NCH];
    int              m_hps   [NCH];
    int              m_rem   [NCH];
    bit              m_en    [NCH];
    bit              m_ens   [NCH];
    bit              m_hpp   [NCH];
    bit              m_enp   [NCH];
    bit              m_act   [NCH];
    longint unsigned m_rc    [NCH];

    task automatic check(input string tag, input logic [RCW-1:0] got, input logic [RCW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
        end
    endtask

    // Predict outputs for the cycle after the coming edge, given what is driven now.
    task automatic predict(input logic rst, input logic v, input cfg_op_e op,
                           input int ch, input int data, output exp_t e);
        e = '0;
        cyc++;
        e.ready = rst;
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_nrise[i] = cyc + PO;
                m_hiend[i] = cyc;
                m_hp[i]    = IHP;
                m_hps[i]   = 0;
                m_rem[i]   = 0;
                m_en[i]    = 1'b1;
                m_ens[i]   = 1'b0;
                m_hpp[i]   = 1'b0;
                m_enp[i]   = 1'b0;
                m_act[i]   = 1'b0;
                m_rc[i]    = 0;
            end
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            bit rise;
            bit done;
            bit issued;
            issued = v && (ch == i) && (op == OP_ADVANCE);
            if (v && (ch == i)) begin
                if (op == OP_SET_HP && data != 0) begin
                    m_hps[i] = data;
                    m_hpp[i] = 1'b1;
                end
                if (op == OP_SET_EN) begin
                    m_ens[i] = data[0];
                    m_enp[i] = 1'b1;
                end
                if (issued) begin
                    m_act[i] = 1'b1;
                    m_rem[i] = data;
                end
            end
            rise = (cyc == m_nrise[i]);
            if (rise) begin
                if (m_hpp[i]) m_hp[i] = m_hps[i];
                if (m_enp[i]) m_en[i] = m_ens[i];
                m_hpp[i]   = 1'b0;
                m_enp[i]   = 1'b0;
                m_hiend[i] = cyc + m_hp[i];
                m_nrise[i] = cyc + 2 * m_hp[i];
                m_rc[i]++;
            end
            done = 1'b0;
            if (issued && data == 0) begin
                done = 1'b1;
            end else if (m_act[i] && rise) begin
                m_rem[i]--;
                if (m_rem[i] == 0) done = 1'b1;
            end
            if (done) m_act[i] = 1'b0;
            e.rise[i]    = rise;
            e.done[i]    = done;
            e.busy[i]    = m_act[i] || done;
            e.clk_out[i] = m_en[i] && (cyc < m_hiend[i]);
`ifdef MULTI_CLOCK_GEN_RISE_COUNT_EN
            e.rc[i*COUNT_W +: COUNT_W] = m_rc[i];
`endif
        end
    endtask

    // Drive one cycle of stimulus, queue its prediction, then compare at the falling edge.
    task automatic step(input logic rst, input logic v, input cfg_op_e op, input int ch, input int data);
        exp_t e;
        exp_t w;
        reset_n      = rst;
        cfg_if.valid = v;
        cfg_if.op    = op;
        cfg_if.ch    = CH_W'(ch);
        cfg_if.data  = CNT_W'(data);
        predict(rst, v, op, ch, data, e);
        sb.push_back(e);
        @(negedge clock);
        w = sb.pop_front();
        check("cfg_ready",  RCW'(cfg_if.ready), RCW'(w.ready));
        check("clk_out",    RCW'(clk_out),      RCW'(w.clk_out));
        check("clk_rise",   RCW'(clk_rise),     RCW'(w.rise));
        check("adv_done",   RCW'(adv_done),     RCW'(w.done));
        check("adv_busy",   RCW'(adv_busy),     RCW'(w.busy));
        check("rise_count", rise_count,         w.rc);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, OP_SET_HP, 0, 0);
    endtask

    task automatic cmd(input cfg_op_e op, input int ch, input int data);
        step(1'b1, 1'b1, op, ch, data);
    endtask

    initial begin
        // Reset, then free-running defaults: first rise one cycle after release, period 4.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, OP_SET_HP, 0, 0);
        idle(9);

        // Half-period change issued during a high phase (also a clk_rise cycle).
        cmd(OP_SET_HP, 1, 5);
        idle(30);

        // Gate channel 2 off and back on; its rises keep coming.
        cmd(OP_SET_EN, 2, 0);
        idle(16);
        cmd(OP_SET_EN, 2, 1);
        idle(12);

        // Advances on channel 0: N=3, N=0, then a restart while busy.
        cmd(OP_ADVANCE, 0, 3);
        idle(16);
        cmd(OP_ADVANCE, 0, 0);
        idle(4);
        cmd(OP_ADVANCE, 0, 3);
        idle(5);
        cmd(OP_ADVANCE, 0, 2);
        idle(12);

        // Ignored commands: zero half period, out-of-range channel, reserved opcode.
        cmd(OP_SET_HP, 0, 0);
        cmd(OP_SET_HP, NCH, 7);
        cmd(OP_SET_EN, NCH, 0);
        cmd(OP_ADVANCE, NCH, 1);
        cmd(OP_RESERVED, 0, 9);
        idle(12);

        // Reset in the middle of an advance abandons it.
        cmd(OP_ADVANCE, 1, 4);
        idle(3);
        step(1'b0, 1'b0, OP_SET_HP, 0, 0);
        step(1'b0, 1'b0, OP_SET_HP, 0, 0);
        idle(12);

        // Random command mix, including same-channel overwrites and out-of-range channels.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) < 3) begin
                cfg_op_e op;
                int      d;
                op = cfg_op_e'($urandom_range(0, 3));
                d  = (op == OP_SET_EN) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 4));
                cmd(op, int'($urandom_range(0, NCH)), d);
            end else begin
                idle(1);
            end
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
